mem_responder: RTL

- Bus target at the far end of the core's memory interface; the core is the initiator, driving address/rw/write data.
- Answers each request from an internal word-addressed RAM or a small MMIO window (output port, free-running timer).
- Inserts a configurable number of wait states and completes every transaction with a one-cycle ack.
- Sits between the core and the top level; cores without a request strobe tie req high.

---
 rtl/mem_responder_pkg.sv | 29 ++
 rtl/mem_responder_if.sv | 15 +
 rtl/mem_responder_mem_array.sv | 21 ++
 rtl/mem_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants, state encoding and address decode for the memory responder.
package mem_responder_pkg;

  localparam logic [31:0] PORT_ADDR        = 32'hFFFF_FFF0;
  localparam logic [31:0] TIMER_ADDR       = 32'hFFFF_FFF4;
  localparam logic [31:0] STATUS_ADDR      = 32'hFFFF_FFF8;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  typedef enum logic [2:0] {TgtRam, TgtPort, TgtTimer, TgtStatus, TgtNone} target_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
  } req_t;

  function automatic target_e decode_addr(input logic [31:0] addr, input int unsigned depth);
    if (addr < depth)              return TgtRam;
    else if (addr == PORT_ADDR)    return TgtPort;
    else if (addr == TIMER_ADDR)   return TgtTimer;
    else if (addr == STATUS_ADDR)  return TgtStatus;
    else                           return TgtNone;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-to-responder memory bus; the core is master, the responder is slave.
interface mem_responder_if;
  logic        req;
  logic [31:0] address;
  logic        rw;
  logic [31:0] datai;
  logic [31:0] data;
  logic        ack;
  logic        err;

  modport master (output req, output address, output rw, output datai,
                  input data, input ack, input err);
  modport slave  (input req, input address, input rw, input datai,
                  output data, output ack, output err);
endinterface

// File: rtl/mem_responder_mem_array.sv
// Word RAM with synchronous write and combinational read; no reset so it can map to block RAM.
module mem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Bus target: accepts one request at a time, waits WAIT_STATES cycles, then acks
// with data from RAM or the MMIO window (port_out, timer, status).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  mem_responder_if.slave bus,
  output logic [31:0] port_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]    r_state, w_state_d;
  logic [3:0]    r_wcnt, w_wcnt_d;
  req_t          r_req, w_cur;
  logic [31:0]   r_timer, w_timer_d;
  logic [31:0]   r_data, r_port;
  logic          r_ack, r_err, r_last_err;
  target_e       w_cur_tgt, w_req_tgt;
  logic [31:0]   w_ram_rdata, w_rdata;
  logic          w_commit, w_enter_resp, w_we;
  logic [AW-1:0] w_waddr, w_raddr;

  // In IDLE the request being accepted is still on the bus, not yet in r_req.
  always_comb begin
    w_cur = r_req;
    if (r_state == StIdle) begin
      w_cur.addr  = bus.address;
      w_cur.rw    = bus.rw;
      w_cur.wdata = bus.datai;
    end
  end

  assign w_cur_tgt = decode_addr(w_cur.addr, DEPTH);
  assign w_req_tgt = decode_addr(r_req.addr, DEPTH);
  assign w_commit  = (r_state == StResp) && r_req.rw;
  assign w_we      = w_commit && (w_req_tgt == TgtRam);
  assign w_waddr   = r_req.addr[AW-1:0];
  assign w_raddr   = w_cur.addr[AW-1:0];

  always_comb begin
    w_state_d = r_state;
    w_wcnt_d  = r_wcnt;
    case (r_state)
      StIdle: begin
        if (bus.req) begin
          w_state_d = (WAIT_STATES > 0) ? StWait : StResp;
          w_wcnt_d  = WaitLoad;
        end
      end
      StWait: begin
        if (r_wcnt == 4'd0) w_state_d = StResp;
        else                w_wcnt_d  = r_wcnt - 4'd1;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_enter_resp = (w_state_d == StResp) && (r_state != StResp);

  // A committing timer write takes precedence over the increment.
  assign w_timer_d = (w_commit && (w_req_tgt == TgtTimer)) ? r_req.wdata : r_timer + 32'd1;

  // Timer reads see w_timer_d, i.e. the value held during the RESP cycle.
  always_comb begin
    case (w_cur_tgt)
      TgtRam:    w_rdata = w_ram_rdata;
      TgtPort:   w_rdata = r_port;
      TgtTimer:  w_rdata = w_timer_d;
      TgtStatus: w_rdata = {31'b0, r_last_err};
      default:   w_rdata = ERR_DATA;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_wcnt     <= 4'd0;
      r_req      <= '0;
      r_timer    <= 32'd0;
      r_data     <= 32'd0;
      r_port     <= 32'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_last_err <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wcnt  <= w_wcnt_d;
      r_timer <= w_timer_d;
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp && (w_cur_tgt == TgtNone);
      if ((r_state == StIdle) && bus.req) r_req <= w_cur;
      if (w_enter_resp && !w_cur.rw) r_data <= w_rdata;
      if (w_commit && (w_req_tgt == TgtPort)) r_port <= r_req.wdata;
      if (r_state == StResp) r_last_err <= r_err;
    end
  end

  mem_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock(clock),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(r_req.wdata),
    .raddr(w_raddr),
    .rdata(w_ram_rdata)
  );

  assign bus.data = r_data;
  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign port_out = r_port;

endmodule
